mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit consuming the EX/MEM pipeline register outputs.
- Drives a variable-latency data-memory bus through a req/ready handshake and stalls the front of the pipeline while an access is outstanding.
- Performs byte/half/word alignment and sign/zero extension, detects misalignment and bus timeout.
- Holds the MEM/WB pipeline register feeding write-back.

Parameters:
- TIMEOUT, 16: max cycles an access may wait for dmem_ready before abort; must be ≥2.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- mem_read_i  in  1  EX/MEM load request
- mem_write_i  in  1  EX/MEM store request
- mem_to_reg_i  in  1  EX/MEM write-back select
- reg_write_i  in  1  EX/MEM register write enable
- funct3_i  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- result_i  in  32  ALU result / effective address
- write_data_i  in  32  store data (rs2)
- rd_i  in  5  destination register
- dmem_req  out  1  bus request
- dmem_we  out  1  bus write
- dmem_addr  out  32  word address {result_i[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  bus completion (read data valid same cycle)
- dmem_rdata  in  32  bus read data
- stall_mem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- reg_write_wb, mem_to_reg_wb  out  1 each  MEM/WB controls
- read_data_wb  out  32  extended load data
- alu_result_wb  out  32  registered result_i
- rd_wb  out  5  registered rd_i
- misalign_err  out  1  one-cycle pulse
- bus_err  out  1  one-cycle pulse

Behaviour:
- Reset: state IDLE, counter 0, every registered output (MEM/WB fields, misalign_err, bus_err) 0. dmem_req, dmem_we and stall_mem are 0 while in reset.
- access = mem_read_i | mem_write_i. If both are high, the access is treated as a load and the write is ignored.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0. No bus request is issued and no stall. On the next edge: misalign_err=1 for one cycle, MEM/WB loads a bubble (reg_write_wb=0).
- Unsupported funct3 (011, 110, 111) is treated as misaligned.
- Combinational request: dmem_req = aligned access in IDLE, or state WAIT. Address, data, be and we are driven from the inputs, which stay stable because EX/MEM is frozen by stall_mem.
- stall_mem = dmem_req & ~dmem_ready & ~timeout_hit.
- FSM IDLE→WAIT: dmem_req=1 and dmem_ready=0. Counter cleared on entry to WAIT.
- Zero-wait access: ready on the first cycle completes the access with no stall and state stays IDLE.
- FSM WAIT→IDLE: on dmem_ready, MEM/WB captures the result. In WAIT the counter increments each cycle without ready.
- Timeout: timeout_hit = (WAIT & count==TIMEOUT-1 & ~dmem_ready). Abort → IDLE, bus_err pulses next cycle, MEM/WB loads a bubble, stall released that cycle. Ready arriving in the same cycle as the limit wins; no error.
- MEM/WB update: every edge.
  - While stall_mem=1: bubble (reg_write_wb=0, mem_to_reg_wb=0, other fields don't-care but held).
  - Otherwise: captures reg_write_i, mem_to_reg_i, result_i, rd_i, and extended load data (0 for non-loads).
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{wd[7:0]}}.
  - SH: be=0011<<addr[1:0], wdata={2{wd[15:0]}}.
  - SW: be=1111.
  - Loads: be=1111.
- Load extract: byte = rdata >> (8*addr[1:0]), half = rdata >> (16*addr[1]). Sign-extended for B/H, zero-extended for BU/HU.
- dmem_ready while dmem_req=0 is ignored.
- Reset mid-access: immediate return to IDLE, request dropped, no error pulses.

Decomposition:
- Shared package: funct3 constants (F3_B/H/W/BU/HU) and the IDLE/WAIT state encoding.
- One combinational sub-module, lsu_align: be/wdata generation, load extraction/extension, misalign detect.
- FSM, counter and MEM/WB register stay in mem_stage_lsu.

Test Plan:
- LW at 0x100, dmem_ready same cycle, rdata=0xDEADBEEF → no stall; next cycle read_data_wb=0xDEADBEEF, reg_write_wb=1, rd_wb=rd_i.
- LB at 0x103, ready after 3 cycles, rdata=0x80xxxxxx → stall_mem high 3 cycles with bubbles in MEM/WB; then read_data_wb=0xFFFFFF80. LBU of the same access gives 0x00000080.
- SH at 0x0A2, wd=0x1234ABCD → dmem_we=1, be=1100, wdata=0xABCDABCD, addr=0x0A0.
- LW at 0x102 → dmem_req never asserted, misalign_err one-cycle pulse, reg_write_wb=0, no stall.
- Load, ready never arrives, TIMEOUT=16 → stall_mem high exactly 16 cycles, then bus_err pulse, bubble, FSM IDLE. Repeat with ready on cycle 16: completes normally, no bus_err.
- rst_n asserted in WAIT → dmem_req=0, stall_mem=0, all outputs 0; the next access behaves normally.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access-size codes and FSM states.
package mem_stage_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane steering: store byte enables/replication, load extraction/extension, misalign detect.
module lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        is_load,
    input  logic [31:0] wd,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'(rdata >> {addr_lo, 3'b000});
        half_v = 16'(rdata >> {addr_lo[1], 4'b0000});

        // Unsupported size codes are folded into the misaligned path.
        case (funct3)
            F3_B, F3_BU: misalign = 1'b0;
            F3_H, F3_HU: misalign = addr_lo[0];
            F3_W:        misalign = |addr_lo;
            default:     misalign = 1'b1;
        endcase

        case (funct3)
            F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_data = {24'd0, byte_v};
            F3_H:    load_data = {{16{half_v[15]}}, half_v};
            F3_HU:   load_data = {16'd0, half_v};
            F3_W:    load_data = rdata;
            default: load_data = 32'd0;
        endcase

        case (funct3[1:0])
            2'b00:   begin be = 4'b0001 << addr_lo; wdata = {4{wd[7:0]}};  end
            2'b01:   begin be = 4'b0011 << addr_lo; wdata = {2{wd[15:0]}}; end
            default: begin be = 4'b1111;            wdata = wd;            end
        endcase
        if (is_load)
            be = 4'b1111;
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: bus handshake FSM with timeout, pipeline stall, and MEM/WB register.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        mem_to_reg_i,
    input  logic        reg_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] result_i,
    input  logic [31:0] write_data_i,
    input  logic [4:0]  rd_i,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mem,
    output logic        reg_write_wb,
    output logic        mem_to_reg_wb,
    output logic [31:0] read_data_wb,
    output logic [31:0] alu_result_wb,
    output logic [4:0]  rd_wb,
    output logic        misalign_err,
    output logic        bus_err
);

    lsu_state_e       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             access, misalign, bad_access;
    logic             req_int, stall_int, timeout_hit;
    logic [31:0]      load_data;

    assign access = mem_read_i | mem_write_i;

    lsu_align u_align (
        .funct3    (funct3_i),
        .addr_lo   (result_i[1:0]),
        .is_load   (mem_read_i),
        .wd        (write_data_i),
        .rdata     (dmem_rdata),
        .be        (dmem_be),
        .wdata     (dmem_wdata),
        .load_data (load_data),
        .misalign  (misalign)
    );

    assign bad_access  = (state == IDLE) & access & misalign;
    assign req_int     = ((state == IDLE) & access & ~misalign) | (state == WAIT);
    assign timeout_hit = (state == WAIT) & (cnt == CNT_W'(TIMEOUT - 1)) & ~dmem_ready;
    assign stall_int   = req_int & ~dmem_ready & ~timeout_hit;

    // Bus-facing outputs are forced low while reset is held; internal logic uses the ungated terms.
    assign dmem_req  = rst_n & req_int;
    assign dmem_we   = rst_n & req_int & mem_write_i & ~mem_read_i;
    assign stall_mem = rst_n & stall_int;
    assign dmem_addr = {result_i[31:2], 2'b00};

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (req_int & ~dmem_ready) begin
                    state_nx = WAIT;
                    cnt_nx   = '0;
                end
            end
            WAIT: begin
                if (dmem_ready | timeout_hit)
                    state_nx = IDLE;
                else
                    cnt_nx = cnt + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            misalign_err  <= 1'b0;
            bus_err       <= 1'b0;
            reg_write_wb  <= 1'b0;
            mem_to_reg_wb <= 1'b0;
            read_data_wb  <= 32'd0;
            alu_result_wb <= 32'd0;
            rd_wb         <= 5'd0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            misalign_err <= bad_access;
            bus_err      <= timeout_hit;
            // MEM/WB boundary: bubble on stall, abort or misalign; otherwise capture EX/MEM.
            if (stall_int | timeout_hit | bad_access) begin
                reg_write_wb  <= 1'b0;
                mem_to_reg_wb <= 1'b0;
            end else begin
                reg_write_wb  <= reg_write_i;
                mem_to_reg_wb <= mem_to_reg_i;
                read_data_wb  <= mem_read_i ? load_data : 32'd0;
                alu_result_wb <= result_i;
                rd_wb         <= rd_i;
            end
        end
    end

endmodule
